vc32_bus_target: RTL and testbench

Memory-side responder for the vc32 CPU's multiplexed 8-bit external bus. Latches the high/low address phases, serves byte reads combinationally from an on-chip byte RAM, commits byte writes, and decodes the 16-bit log port at 0xFFFE/0xFFFF into a small FIFO. The FIFO drains over a valid/ready stream. Sits between the CPU pins (uo_out/uio_out in, ui_in out) and the board-level memory/debug fabric.

---
 rtl/vc32_bus_pkg.sv | 31 +++
 rtl/vc32_bus_target_if.sv | 34 +++
 rtl/vc32_log_fifo.sv | 65 ++++++
 rtl/vc32_bus_target.sv | 129 ++++++++++++
 tb/tb_vc32_bus_target.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc32_bus_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : vc32_bus_pkg                                                 |
// | Purpose  : Shared constants and helpers for the vc32 external bus target |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package vc32_bus_pkg;

   typedef logic [7:0] byte_t;

   // Log port window: word address {A[15:1]} that maps to 0xFFFE/0xFFFF
   localparam logic [14:0] LOG_ADDR_HI = 15'h7FFF;

   // Status byte layout: overflow flag in the MSB, fill count in the low bits
   localparam int OVF_BIT = 7;
   localparam int CNT_MSB = 4;
   localparam int CNT_LSB = 0;

   function automatic byte_t status_byte(input logic ovf, input logic [CNT_MSB:CNT_LSB] cnt);
      byte_t s;
      s                  = '0;
      s[OVF_BIT]         = ovf;
      s[CNT_MSB:CNT_LSB] = cnt;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vc32_bus_target_if.sv
// ---------------------------------------------------------------------------
// | Module   : vc32_bus_target_if                                           |
// | Purpose  : CPU-side multiplexed bus pins plus log stream handshake       |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface vc32_bus_target_if;
   logic [7:0]  bus_ad;
   logic        bus_ind;
   logic        bus_write;
   logic        bus_latch_hi;
   logic        bus_latch_lo;
   logic [7:0]  bus_rdata;
   logic [15:0] log_data;
   logic        log_valid;
   logic        log_ready;
   logic        log_overflow;

   // CPU pins and log consumer side
   modport master (
      output bus_ad, bus_ind, bus_write, bus_latch_hi, bus_latch_lo, log_ready,
      input  bus_rdata, log_data, log_valid, log_overflow
   );

   // Memory-side responder
   modport slave (
      input  bus_ad, bus_ind, bus_write, bus_latch_hi, bus_latch_lo, log_ready,
      output bus_rdata, log_data, log_valid, log_overflow
   );
endinterface

`default_nettype wire

// File: rtl/vc32_log_fifo.sv
// ---------------------------------------------------------------------------
// | Module   : vc32_log_fifo                                                |
// | Purpose  : Small synchronous FIFO for 16-bit log words                  |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module vc32_log_fifo #(
   parameter int DEPTH = 4
) (
   input  wire logic                       clk,
   input  wire logic                       reset,
   input  wire logic                       push,
   input  wire logic [15:0]                din,
   input  wire logic                       pop,
   output logic      [15:0]                dout,
   output logic                            empty,
   output logic                            full,
   output logic      [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_pop;
   logic          w_do_push;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   // Head reads as zero while empty so the stream output is clean after reset
   assign dout      = empty ? 16'h0000 : r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap on their natural width
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage, not reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (!reset && w_do_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/vc32_bus_target.sv
// ---------------------------------------------------------------------------
// | Module   : vc32_bus_target                                              |
// | Purpose  : vc32 external bus responder: address latches, byte RAM and  |
// |            optional 16-bit log port at 0xFFFE/0xFFFF feeding a FIFO.    |
// |            Log port built only when VC32_BUS_LOG_EN is defined.         |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module vc32_bus_target
   import vc32_bus_pkg::*;
#(
   parameter int MEM_BYTES = 4096,
   parameter int LOG_DEPTH = 4
) (
   input wire logic         clk,
   input wire logic         reset,
   vc32_bus_target_if.slave bus
);
   localparam int MAW = $clog2(MEM_BYTES);

   logic [7:0]     r_addr_hi;
   logic [6:0]     r_addr_lo;
   logic [15:0]    w_addr;
   logic [MAW-1:0] w_mem_idx;
   logic           w_log_win;
   logic [7:0]     r_mem [MEM_BYTES];

   assign w_addr    = {r_addr_hi, r_addr_lo, bus.bus_ind};
   assign w_mem_idx = w_addr[MAW-1:0];

   // Address phases arrive on the falling edge so the read is ready by the next rise
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         r_addr_hi <= 8'h00;
         r_addr_lo <= 7'h00;
      end else begin
         if (bus.bus_latch_hi) r_addr_hi <= bus.bus_ad;
         if (bus.bus_latch_lo) r_addr_lo <= bus.bus_ad[7:1];
      end
   end

   // Byte RAM write; log-window writes never reach the array, reset blocks writes
   always_ff @(posedge clk) begin
      if (!reset && bus.bus_write && !w_log_win) r_mem[w_mem_idx] <= bus.bus_ad;
   end

`ifdef VC32_BUS_LOG_EN
   localparam int CW = $clog2(LOG_DEPTH) + 1;

   logic [7:0]    r_log_lo;
   logic          r_overflow;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [15:0]   w_dout;
   logic [CW-1:0] w_count;
   logic [7:0]    w_status;

   assign w_log_win = (w_addr[15:1] == LOG_ADDR_HI);
   assign w_push    = bus.bus_write && w_log_win && bus.bus_ind;
   assign w_pop     = !w_empty && bus.log_ready;
   assign w_status  = status_byte(r_overflow, 5'(w_count));

   // Low half of the log word is staged here; the high-byte write pushes both
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_log_lo <= 8'h00;
      end else if (bus.bus_write && w_log_win && !bus.bus_ind) begin
         r_log_lo <= bus.bus_ad;
      end
   end

   // Sticky drop flag: a push into a full FIFO with no pop to make room
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   vc32_log_fifo #(
      .DEPTH (LOG_DEPTH)
   ) u_log_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   ({bus.bus_ad, r_log_lo}),
      .pop   (w_pop),
      .dout  (w_dout),
      .empty (w_empty),
      .full  (w_full),
      .count (w_count)
   );

   assign bus.log_data     = w_dout;
   assign bus.log_valid    = !w_empty;
   assign bus.log_overflow = r_overflow;

   // Read mux: log window returns the status byte (low) or zero (high)
   always_comb begin
      bus.bus_rdata = r_mem[w_mem_idx];
      if (w_log_win) bus.bus_rdata = bus.bus_ind ? 8'h00 : w_status;
   end
`else
   logic                 w_unused_ready;
   logic [15-MAW:0]      w_unused_addr;
   logic [4:0]           w_unused_depth;

   assign w_log_win        = 1'b0;
   assign w_unused_ready   = bus.log_ready;
   assign w_unused_addr    = w_addr[15:MAW];
   assign w_unused_depth   = 5'(LOG_DEPTH);
   assign bus.log_data     = 16'h0000;
   assign bus.log_valid    = 1'b0;
   assign bus.log_overflow = 1'b0;

   // Read mux: plain RAM everywhere, top addresses alias modulo the RAM size
   always_comb begin
      bus.bus_rdata = r_mem[w_mem_idx];
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc32_bus_target.sv
// ---------------------------------------------------------------------------
// | Module   : tb_vc32_bus_target                                           |
// | Purpose  : Directed scoreboard bench for vc32_bus_target                |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vc32_bus_target;
   localparam int SEL_RDATA = 0;
   localparam int SEL_VALID = 1;
   localparam int SEL_DATA  = 2;
   localparam int SEL_OVF   = 3;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] exp;
   } probe_t;

   logic clk = 1'b0;
   logic reset;

   probe_t      pq[$];
   logic [15:0] lq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   event        do_probe;

   always #5 clk = ~clk;

   vc32_bus_target_if bus ();

   vc32_bus_target #(
      .MEM_BYTES (4096),
      .LOG_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Probe monitor: compares the selected output against queued expectations
   initial begin
      probe_t      p;
      logic [15:0] act;
      forever begin
         @(do_probe);
         #1;
         while (pq.size() > 0) begin
            p = pq.pop_front();
            case (p.sel)
               SEL_RDATA: act = {8'h00, bus.bus_rdata};
               SEL_VALID: act = {15'h0, bus.log_valid};
               SEL_DATA:  act = bus.log_data;
               default:   act = {15'h0, bus.log_overflow};
            endcase
            n_cmp++;
            if (act !== p.exp) begin
               n_err++;
               $display("FAIL %s: got %h expected %h", p.name, act, p.exp);
            end
         end
      end
   end

   // Stream monitor: every accepted log word must match the scoreboard head
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (bus.log_valid === 1'b1 && bus.log_ready === 1'b1) begin
            n_cmp++;
            if (lq.size() == 0) begin
               n_err++;
               $display("FAIL log_stream_extra: got %h expected no entry", bus.log_data);
            end else begin
               e = lq.pop_front();
               if (bus.log_data !== e) begin
                  n_err++;
                  $display("FAIL log_stream: got %h expected %h", bus.log_data, e);
               end
            end
         end
      end
   end

   task automatic probe(input string name, input int sel, input logic [15:0] exp);
      @(posedge clk);
      #2;
      pq.push_back('{name: name, sel: sel, exp: exp});
      -> do_probe;
      #2;
   endtask

   task automatic probe_rd(input string name, input logic ind, input logic [7:0] exp);
      @(posedge clk);
      #1 bus.bus_ind = ind;
      #1;
      pq.push_back('{name: name, sel: SEL_RDATA, exp: {8'h00, exp}});
      -> do_probe;
      #2;
   endtask

   task automatic latch(input logic hi, input logic lo, input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.bus_ad       = b;
      bus.bus_latch_hi = hi;
      bus.bus_latch_lo = lo;
      @(negedge clk);
      #1;
      bus.bus_latch_hi = 1'b0;
      bus.bus_latch_lo = 1'b0;
   endtask

   task automatic wr(input logic ind, input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.bus_ind   = ind;
      bus.bus_ad    = d;
      bus.bus_write = 1'b1;
      @(posedge clk);
      #1 bus.bus_write = 1'b0;
   endtask

   task automatic drain(input string name);
      @(posedge clk);
      #1 bus.log_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (lq.size() == 0) break;
      end
      #1 bus.log_ready = 1'b0;
      if (lq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got %0d entries left expected 0", name, lq.size());
         lq.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b1;
      bus.bus_ad       = 8'h00;
      bus.bus_ind      = 1'b0;
      bus.bus_write    = 1'b0;
      bus.bus_latch_hi = 1'b0;
      bus.bus_latch_lo = 1'b0;
      bus.log_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      probe("rst_valid", SEL_VALID, 16'h0);
      probe("rst_data",  SEL_DATA,  16'h0);
      probe("rst_ovf",   SEL_OVF,   16'h0);

      // Separate latches, 0x0122/0x0123
      latch(1'b1, 1'b0, 8'h01);
      latch(1'b0, 1'b1, 8'h22);
      wr(1'b0, 8'hA5);
      wr(1'b1, 8'h5A);
      probe_rd("ram_0122", 1'b0, 8'hA5);
      probe_rd("ram_0123", 1'b1, 8'h5A);
      latch(1'b1, 1'b0, 8'h11);
      probe_rd("ram_alias_1123", 1'b1, 8'h5A);

      // Both strobes together: A = 0x4746/0x4747, RAM index 0x746/0x747
      latch(1'b1, 1'b1, 8'h47);
      wr(1'b0, 8'h3C);
      wr(1'b1, 8'hC3);
      probe_rd("ram_4746", 1'b0, 8'h3C);
      probe_rd("ram_4747", 1'b1, 8'hC3);
      latch(1'b1, 1'b0, 8'h07);
      probe_rd("ram_alias_0746", 1'b0, 8'h3C);

`ifdef VC32_BUS_LOG_EN
      latch(1'b1, 1'b0, 8'hFF);
      latch(1'b0, 1'b1, 8'hFE);
      wr(1'b0, 8'h34);
      wr(1'b1, 8'h12);
      lq.push_back(16'h1234);
      probe("log_valid_1", SEL_VALID, 16'h1);
      probe("log_head_1234", SEL_DATA, 16'h1234);
      probe_rd("status_1", 1'b0, 8'h01);
      probe_rd("status_hi", 1'b1, 8'h00);
      drain("drain_1");
      probe("log_valid_empty1", SEL_VALID, 16'h0);

      // Fill, then push concurrent with pop while full
      for (int d = 8'h0A; d <= 8'h0D; d++) begin
         wr(1'b1, 8'(d));
         lq.push_back({8'(d), 8'h34});
      end
      probe_rd("status_full", 1'b0, 8'h04);
      @(posedge clk);
      #1;
      bus.bus_ind   = 1'b1;
      bus.bus_ad    = 8'h0E;
      bus.bus_write = 1'b1;
      bus.log_ready = 1'b1;
      lq.push_back(16'h0E34);
      @(posedge clk);
      #1;
      bus.bus_write = 1'b0;
      bus.log_ready = 1'b0;
      probe_rd("status_pushpop", 1'b0, 8'h04);
      probe("ovf_pushpop", SEL_OVF, 16'h0);
      drain("drain_pushpop");
      probe("log_valid_empty2", SEL_VALID, 16'h0);

      // Five pushes into a four-deep FIFO: the fifth is dropped
      for (int d = 1; d <= 5; d++) begin
         wr(1'b1, 8'(d));
         if (d <= 4) lq.push_back({8'(d), 8'h34});
      end
      probe_rd("status_ovf", 1'b0, 8'h84);
      probe("ovf_set", SEL_OVF, 16'h1);
      drain("drain_ovf");
      probe("log_valid_empty3", SEL_VALID, 16'h0);
      probe_rd("status_ovf_empty", 1'b0, 8'h80);

      // Reset with two entries queued and a fresh low byte staged
      wr(1'b0, 8'h66);
      wr(1'b1, 8'h21);
      wr(1'b1, 8'h22);
      probe_rd("status_two", 1'b0, 8'h82);
      @(posedge clk);
      #1 reset = 1'b1;
      probe("rst_flush_valid", SEL_VALID, 16'h0);
      probe("rst_flush_ovf",   SEL_OVF,   16'h0);
      probe("rst_flush_data",  SEL_DATA,  16'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      latch(1'b1, 1'b0, 8'hFF);
      latch(1'b0, 1'b1, 8'hFE);
      probe_rd("status_after_rst", 1'b0, 8'h00);
      wr(1'b1, 8'h77);
      lq.push_back(16'h7700);
      probe("log_lo_lost", SEL_DATA, 16'h7700);
      drain("drain_rst");
`else
      // Without the log port 0xFFFE/0xFFFF is ordinary RAM at 0xFFE/0xFFF
      latch(1'b1, 1'b0, 8'hFF);
      latch(1'b0, 1'b1, 8'hFE);
      wr(1'b0, 8'h34);
      wr(1'b1, 8'h12);
      probe_rd("ram_fffe", 1'b0, 8'h34);
      probe_rd("ram_ffff", 1'b1, 8'h12);
      bus.log_ready = 1'b1;
      probe("nolog_valid", SEL_VALID, 16'h0);
      probe("nolog_ovf",   SEL_OVF,   16'h0);
      probe("nolog_data",  SEL_DATA,  16'h0);
      bus.log_ready = 1'b0;
      latch(1'b1, 1'b0, 8'h0F);
      probe_rd("ram_alias_0ffe", 1'b0, 8'h34);
      probe_rd("ram_alias_0fff", 1'b1, 8'h12);
`endif

      repeat (3) @(posedge clk);
      if (lq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL log_leftover: got %0d entries expected 0", lq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
